// File: rtl/intdp_pkg.sv
// Shared definitions for the 16-bit integer datapath and its controller: widths,
// instruction field positions, controller states and ALU opcodes.
package intdp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADR_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REP_W  = 4;

  // Instruction field bit positions; bit 0 is reserved and ignored.
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned W_MSB     = 11;
  localparam int unsigned W_LSB     = 9;
  localparam int unsigned R_MSB     = 8;
  localparam int unsigned R_LSB     = 6;
  localparam int unsigned S_MSB     = 5;
  localparam int unsigned S_LSB     = 3;
  localparam int unsigned S_SEL_BIT = 2;
  localparam int unsigned WB_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  alu_op;
    logic [ADR_W-1:0] w_adr;
    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] s_adr;
    logic             s_sel;
    logic             wb;
  } ir_t;

  // ALU opcodes shared with alu16.
  localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [OP_W-1:0] ALU_SHL  = 4'h5;
  localparam logic [OP_W-1:0] ALU_SHR  = 4'h6;
  localparam logic [OP_W-1:0] ALU_PASS = 4'h7;

  function automatic ir_t decode_instr(input logic [DATA_W-1:0] word);
    ir_t ir;
    ir.alu_op = word[OP_MSB:OP_LSB];
    ir.w_adr  = word[W_MSB:W_LSB];
    ir.r_adr  = word[R_MSB:R_LSB];
    ir.s_adr  = word[S_MSB:S_LSB];
    ir.s_sel  = word[S_SEL_BIT];
    ir.wb     = word[WB_BIT];
    return ir;
  endfunction

endpackage

// File: rtl/integer_datapath_ctrl.sv
// Multi-cycle sequencer driving the register file + ALU datapath from encoded instructions.
// Define INTDP_CTRL_FLAGS_EN to register the c/n/z flags; otherwise flag outputs are tied to 0.
module integer_datapath_ctrl
  import intdp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] imm,
  input  logic [REP_W-1:0]  rep,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              c_in,
  input  logic              n_in,
  input  logic              z_in,
  output logic              W_En,
  output logic [ADR_W-1:0]  W_Adr,
  output logic [ADR_W-1:0]  R_Adr,
  output logic [ADR_W-1:0]  S_Adr,
  output logic [DATA_W-1:0] DS,
  output logic              S_Sel,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_z
);

  state_e              state_q, state_d;
  ir_t                 ir_q, ir_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [REP_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q;
  logic                capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = decode_instr(instr);
          imm_d   = imm;
          cnt_d   = rep;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // cnt_q counts remaining extra iterations, so zero marks the final one.
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= alu_out;
    end
  end

`ifdef INTDP_CTRL_FLAGS_EN
  logic flag_c_q, flag_n_q, flag_z_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (capture) begin
      flag_c_q <= c_in;
      flag_n_q <= n_in;
      flag_z_q <= z_in;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

  logic unused_inputs;
  assign unused_inputs = instr[0];
`else
  assign flag_c = 1'b0;
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{instr[0], c_in, n_in, z_in};
`endif

  // Datapath fields follow IR in every state so addresses stay stable; only W_En is gated.
  always_comb begin
    instr_ready = (state_q == IDLE);
    busy        = (state_q == EXEC) || (state_q == DONE);
    done        = (state_q == DONE);
    W_En        = (state_q == EXEC) && ir_q.wb;
    W_Adr       = ir_q.w_adr;
    R_Adr       = ir_q.r_adr;
    S_Adr       = ir_q.s_adr;
    S_Sel       = ir_q.s_sel;
    ALU_OP      = ir_q.alu_op;
    DS          = imm_q;
    result      = result_q;
  end

endmodule

// File: tb/tb_integer_datapath_ctrl.sv
// Self-checking bench for integer_datapath_ctrl with a small register file + ALU stand-in.
module tb_integer_datapath_ctrl;

`ifdef INTDP_CTRL_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] imm = '0;
  logic [3:0]  rep = '0;
  logic [15:0] alu_y;
  logic        c_y, n_y, z_y;
  logic        W_En;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [15:0] DS;
  logic        S_Sel;
  logic [3:0]  ALU_OP;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_c, flag_n, flag_z;

  int n_chk = 0;
  int n_fail = 0;
  int wen_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  integer_datapath_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .rep(rep), .alu_out(alu_y),
    .c_in(c_y), .n_in(n_y), .z_in(z_y),
    .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .DS(DS), .S_Sel(S_Sel),
    .ALU_OP(ALU_OP), .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z)
  );

  // Stand-in datapath: register file preloaded with rf[i] = i * 16'h0101.
  logic [15:0] rf [8];
  logic        rf_loaded = 1'b0;
  logic [15:0] op_a, op_b;

  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'(i) * 16'h0101;
      rf_loaded <= 1'b1;
    end else if (W_En) begin
      rf[W_Adr] <= alu_y;
    end
  end

  always_comb begin
    op_a  = rf[R_Adr];
    op_b  = S_Sel ? DS : rf[S_Adr];
    alu_y = op_a;
    c_y   = 1'b0;
    case (ALU_OP)
      4'h0: {c_y, alu_y} = {1'b0, op_a} + {1'b0, op_b};
      4'h1: begin alu_y = op_a - op_b; c_y = (op_a < op_b); end
      4'h2: alu_y = op_a & op_b;
      4'h3: alu_y = op_a | op_b;
      4'h4: alu_y = op_a ^ op_b;
      4'h5: begin alu_y = op_a << 1; c_y = op_a[15]; end
      4'h6: begin alu_y = op_a >> 1; c_y = op_a[0]; end
      4'h7: alu_y = op_b;
      default: alu_y = op_a;
    endcase
    n_y = alu_y[15];
    z_y = (alu_y == 16'h0000);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: after an accept, cycles 1..rep+1 execute, cycle rep+2 is done, then idle.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_instr = '0;
  logic [15:0] m_imm = '0;
  int          m_rep = 0;
  logic [15:0] m_res = '0;
  logic [2:0]  m_flags = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_k      = 0;
      m_instr  = '0;
      m_imm    = '0;
      m_rep    = 0;
      m_res    = '0;
      m_flags  = '0;
    end else if (!m_active) begin
      if (instr_valid) begin
        m_active = 1'b1;
        m_k      = 1;
        m_instr  = instr;
        m_imm    = imm;
        m_rep    = int'(rep);
      end
    end else begin
      if (m_k == m_rep + 1) begin
        m_res   = alu_y;
        m_flags = FLAGS_EN ? {c_y, n_y, z_y} : 3'b000;
      end
      if (m_k == m_rep + 2) m_active = 1'b0;
      else m_k++;
    end
  end

  always @(negedge clk) begin
    bit exp_exec, exp_done;
    exp_exec = m_active && (m_k <= m_rep + 1);
    exp_done = m_active && (m_k == m_rep + 2);
    chk("instr_ready", 32'(instr_ready), 32'(!m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(exp_done));
    chk("W_En", 32'(W_En), 32'(exp_exec && m_instr[1]));
    chk("W_Adr", 32'(W_Adr), 32'(m_instr[11:9]));
    chk("R_Adr", 32'(R_Adr), 32'(m_instr[8:6]));
    chk("S_Adr", 32'(S_Adr), 32'(m_instr[5:3]));
    chk("S_Sel", 32'(S_Sel), 32'(m_instr[2]));
    chk("ALU_OP", 32'(ALU_OP), 32'(m_instr[15:12]));
    chk("DS", 32'(DS), 32'(m_imm));
    chk("result", 32'(result), 32'(m_res));
    chk("flags", 32'({flag_c, flag_n, flag_z}), 32'(m_flags));
    if (W_En) wen_cnt++;
    if (done) done_cnt++;
  end

  task automatic issue(input logic [15:0] i, input logic [15:0] im, input logic [3:0] r,
                       input bit keep_valid, output time ta);
    bit hs;
    instr = i; imm = im; rep = r; instr_valid = 1'b1; ta = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = instr_ready;
      @(posedge clk);
      if (hs) begin
        ta = $time;
        break;
      end
    end
    if (ta == 0) chk("accept_timeout", 32'd0, 32'd1);
    #1;
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after accept) in which done is seen.
  task automatic wait_done(input time ta, output int cyc);
    cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = int'(($time - ta + 5) / 10);
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    time ta, tb_t;
    int  dc;

    #3;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_W_En", 32'(W_En), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_addr", 32'({W_Adr, R_Adr, S_Adr, S_Sel, ALU_OP}), 32'd0);
    #9 reset = 1'b0;
    @(posedge clk); #1;

    // Register op: rf1 = rf2 + rf3 = 0x0202 + 0x0303.
    wen_cnt = 0;
    issue(16'h029A, 16'h0000, 4'd0, 1'b0, ta);
    chk("t1_W_En", 32'(W_En), 32'd1);
    chk("t1_addrs", 32'({W_Adr, R_Adr, S_Adr, S_Sel}), 32'({3'd1, 3'd2, 3'd3, 1'b0}));
    wait_done(ta, dc);
    chk("t1_done_cycle", 32'(dc), 32'd2);
    chk("t1_wen_count", 32'(wen_cnt), 32'd1);
    chk("t1_result", 32'(result), 32'h0505);
    chk("t1_rf1", 32'(rf[1]), 32'h0505);

    // Immediate with repeat: rf4 -= 0x00FF four times from 0x0404.
    wen_cnt = 0;
    issue(16'h1906, 16'h00FF, 4'd3, 1'b0, ta);
    chk("t2_DS", 32'(DS), 32'h00FF);
    wait_done(ta, dc);
    chk("t2_done_cycle", 32'(dc), 32'd5);
    chk("t2_wen_count", 32'(wen_cnt), 32'd4);
    chk("t2_result", 32'(result), 32'h0008);
    chk("t2_rf4", 32'(rf[4]), 32'h0008);

    // Compare-only: rf5 - rf5 sets zero, no write.
    wen_cnt = 0;
    issue(16'h1B68, 16'h0000, 4'd0, 1'b0, ta);
    wait_done(ta, dc);
    chk("t3_done_cycle", 32'(dc), 32'd2);
    chk("t3_wen_count", 32'(wen_cnt), 32'd0);
    chk("t3_result", 32'(result), 32'h0000);
    chk("t3_flag_z", 32'(flag_z), 32'(FLAGS_EN));
    chk("t3_rf5", 32'(rf[5]), 32'h0505);

    // Handshake: A (rf6 |= rf7, rep 2) then B (rf2 <<= 1, rep 1) held pending.
    issue(16'h3DBA, 16'h0000, 4'd2, 1'b1, ta);
    issue(16'h5482, 16'h0000, 4'd1, 1'b0, tb_t);
    chk("t4_accept_gap", 32'(int'((tb_t - ta) / 10)), 32'd5);
    chk("t4_resultA", 32'(result), 32'h0707);
    wait_done(tb_t, dc);
    chk("t4_done_cycle", 32'(dc), 32'd3);
    chk("t4_resultB", 32'(result), 32'h0808);
    chk("t4_rf2", 32'(rf[2]), 32'h0808);
    chk("t4_rf6", 32'(rf[6]), 32'h0707);

    // Reset mid-op in the 2nd EXEC cycle of rf3 += rf3, rep 5.
    wen_cnt = 0;
    done_cnt = 0;
    issue(16'h06DA, 16'h0000, 4'd5, 1'b0, ta);
    @(posedge clk); #1;
    chk("t5_W_En_before", 32'(W_En), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_W_En_reset", 32'(W_En), 32'd0);
    chk("t5_busy_reset", 32'(busy), 32'd0);
    chk("t5_ready_reset", 32'(instr_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_ready_after", 32'(instr_ready), 32'd1);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_wen_count", 32'(wen_cnt), 32'd1);
    chk("t5_rf3", 32'(rf[3]), 32'h0606);
    chk("t5_result", 32'(result), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/integer_datapath_ctrl.md
# integer_datapath_ctrl

Multi-cycle sequencer that drives the 16-bit integer datapath (register file plus ALU) from a stream of encoded instructions. It accepts one instruction per valid/ready handshake, holds it in an instruction register, and drives the datapath's write-enable, address, immediate, S-mux select and ALU-op inputs. Each instruction executes for a programmable repeat count, then the block reports completion with the captured result and flags. It sits between the instruction source (test host or fetch unit) and the datapath in the integer core top level.

## Interface
- No parameters. Data width is fixed at 16 and register address width at 3; both come from the shared package.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept (IDLE only)
- instr  in  16  [15:12] alu_op, [11:9] w_adr, [8:6] r_adr, [5:3] s_adr, [2] s_sel, [1] wb, [0] reserved (ignored)
- imm  in  16  immediate, latched with instr
- rep  in  4  extra iterations; instruction executes rep+1 times
- alu_out  in  16  datapath Alu_Out
- c_in, n_in, z_in  in  1 each  datapath flags
- W_En  out  1  to datapath
- W_Adr, R_Adr, S_Adr  out  3 each  to datapath
- DS  out  16  to datapath
- S_Sel  out  1  to datapath
- ALU_OP  out  4  to datapath
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse
- result  out  16  Alu_Out captured on the final iteration
- flag_c, flag_n, flag_z  out  1 each  flags captured on the final iteration (see Configuration)

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: instr_ready=1. When instr_valid&&instr_ready at an edge, latch instr, imm and rep into IR/IMM/CNT, then go to EXEC.
- EXEC: the datapath fields are driven combinationally from IR. DS=IMM. W_En=IR.wb. At each edge, if CNT==0, capture alu_out into result and c_in/n_in/z_in into the flags, then go to DONE. Otherwise decrement CNT and stay in EXEC.
- DONE: done=1 and W_En=0 for exactly one cycle, then return to IDLE.
- Outside EXEC, W_En=0. The other datapath outputs hold their IR values, so the addresses stay stable.
- A repeat re-reads the register file each iteration. For example, a shift with w_adr==r_adr applies the shift rep+1 times.
- wb=0: the ALU is evaluated and result and flags are captured, but nothing is written (compare/test).
- instr_valid outside IDLE is ignored. The source must hold instr, imm and rep until the handshake.

## Timing
- Reset values: state=IDLE, instr_ready=1, IR/IMM/CNT/result/flags=0, W_En=0, all datapath outputs 0, busy=0, done=0.
- Reset is asynchronous. Asserting it mid-EXEC drops W_En in the same cycle with no further write. Writes already committed remain.
- Latency: accept at edge 0; EXEC during cycles 1..rep+1; done during cycle rep+2; instr_ready high again in cycle rep+3. Back-to-back throughput is one instruction per rep+3 cycles.
- rep=15 gives 16 EXEC cycles. CNT never wraps.
- result and flags hold their value until the next final iteration.

## Configuration
- INTDP_CTRL_FLAGS_EN defined: flag_c/n/z are registered as described.
- INTDP_CTRL_FLAGS_EN undefined: the flag registers are removed and flag_c/n/z are tied to 0. The c_in/n_in/z_in ports remain but are unused.
- result is present in both cases.

## Structure
- Package intdp_pkg holds:
  - width constants DATA_W=16 and ADR_W=3
  - instr field bit positions
  - the state enum {IDLE, EXEC, DONE}
  - ALU_OP localparams shared with alu16
- No sub-module is needed; the repeat counter and FSM stay inline.
- The integer core top instantiates integer_datapath_ctrl beside the datapath and wires alu_out and the flags back.

## Test plan
- Register op: after reset, instr=16'h029A (op 0, W=1, R=2, S=3, wb), rep=0. Required: W_En high for exactly 1 cycle with W_Adr=1, R_Adr=2, S_Adr=3, S_Sel=0; done pulses 2 cycles after accept; result equals the datapath output.
- Immediate with repeat: instr=16'h1906 (op 1, W=R=4, S_Sel=1, wb), imm=16'h00FF, rep=3. Required: DS=16'h00FF and W_En high for 4 consecutive cycles; done 5 cycles after accept.
- Compare-only: instr with wb=0 and rep=0. Required: W_En never asserted; flags and result updated; register contents unchanged on readback.
- Handshake: hold instr_valid high through a rep=2 instruction with a second instruction pending. Required: the second instruction is accepted only in the IDLE cycle after done, and instr_ready=0 throughout EXEC and DONE.
- Reset mid-op: assert reset in the 2nd EXEC cycle of rep=5. Required: W_En=0 and state=IDLE immediately; busy=0; no done pulse; instr_ready=1 after release.
- Flags macro: build without INTDP_CTRL_FLAGS_EN and drive z_in=1 on the final iteration. Required: flag_z stays 0. With the macro defined, flag_z=1 after done.
